mdu_ctrl: RTL and testbench
===========================

// Module: mdu_ctrl
// PURPOSE
//  Multi-cycle multiply/divide controller owning the HI/LO register pair.
//  Sits beside the single-cycle ALU in EX and sequences MULT/MULTU/DIV/DIVU
//  over a fixed number of cycles. Serves MFHI/MFLO/MTHI/MTLO.
//  Raises a stall to the pipeline while an MDU access conflicts with a busy operation.
// PARAMETERS
//  MUL_CYCLES  5   busy cycles for MULT/MULTU (1..255)
//  DIV_CYCLES  10  busy cycles for DIV/DIVU (1..255)
// PORTS
//  clk    in   1   clock, rising edge
//  rst_n  in   1   asynchronous active-low reset
//  req    in   1   EX holds an MDU instruction this cycle
//  op     in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO
//  a      in   32  rs operand
//  b      in   32  rt operand
//  flush  in   1   EX instruction is killed this cycle
//  stall  out  1   hold EX (req && busy), combinational
//  busy   out  1   multi-cycle operation in flight (registered)
//  rdata  out  32  MFHI -> hi, MFLO -> lo, else 0 (combinational)
//  hi     out  32  HI register
//  lo     out  32  LO register
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, busy=0, hi=0, lo=0, count=0, pending regs=0.
//  - accept = req && !flush && !busy; evaluated every cycle; flush wins over req.
//  - stall = req && busy. Applies to all 8 ops, including MF*/MT*. Not gated by flush.
//  - FSM states: IDLE, MUL, DIV.
//    IDLE --accept & op=0/1--> MUL: loads count=MUL_CYCLES; latches the 64-bit product into pending.
//    IDLE --accept & op=2/3--> DIV: loads count=DIV_CYCLES; latches quotient and remainder into pending.
//    MUL/DIV: count decrements each edge.
//    At the edge where count==1: commit pending to {hi,lo}; go to IDLE.
//  - Timing: accept in cycle T. busy=1 in cycles T+1..T+N. HI/LO update at the end of cycle T+N.
//    busy=0 and new HI/LO are visible in cycle T+N+1. A request in cycle T+N stalls.
//  - MTHI/MTLO: on accept, hi/lo <= a at that edge. No busy.
//  - MFHI/MFLO: rdata is valid in the accept cycle. Never returns pre-commit data while busy.
//  - MULT: signed 32x32->64, HI=upper, LO=lower. MULTU: unsigned.
//  - DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend a.
//    0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. DIVU: unsigned.
//  - Divide by zero (b==0): still busy for DIV_CYCLES; HI/LO left unchanged at commit.
//  - flush while busy does not abort; an in-flight op always commits (precise-exception rule).
//  - Reset mid-operation: immediately IDLE with hi=lo=0. Nothing commits.
//  - Operands are sampled only at accept. Later changes on a/b have no effect.
// TESTING
//  1. MULT a=0xFFFFFFFD b=5 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFF1.
//  2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001 after 5 cycles.
//  3. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//     DIVU a=7 b=0 -> busy 10 cycles, hi/lo unchanged.
//  4. MFHI issued 1 cycle after a DIV starts -> stall=1 for 10 cycles.
//     Then rdata = new hi in the accept cycle.
//  5. MTLO a=0x12345678 with flush=1 -> lo unchanged.
//     Same with flush=0 -> lo=0x12345678 next cycle, busy stays 0.
//  6. rst_n low 3 cycles into a MULT -> busy=0 hi=lo=0 at once.
//     After release, no commit occurs.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning the HI/LO register pair.
// Products and quotients are computed combinationally from the operands
// present at accept and parked in pending registers. They are committed to
// HI/LO only after the fixed busy window has elapsed.
module mdu_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state;
  logic [7:0]  count;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_ok;

  logic        accept;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign accept = req && !flush && !busy;
  assign stall  = req && busy;
  assign rdata  = (op == 3'd4) ? hi : (op == 3'd5) ? lo : 32'd0;

  // Multiply and divide datapath. Signed division works on magnitudes so
  // that 0x80000000 / -1 wraps cleanly; a zero divisor is replaced by 1 to
  // keep the divider defined, and the result is discarded at commit anyway.
  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    a_neg  = (op == 3'd2) && a[31];
    b_neg  = (op == 3'd2) && b[31];
    a_mag  = a_neg ? -a : a;
    b_mag  = (b == 32'd0) ? 32'd1 : (b_neg ? -b : b);
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
  end

  // Sequencer: accept in IDLE, count down the busy window, commit at count==1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      count   <= 8'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_ok <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              3'd0, 3'd1: begin
                state   <= MUL;
                busy    <= 1'b1;
                count   <= 8'(MUL_CYCLES);
                {pend_hi, pend_lo} <= op[0] ? prod_u : prod_s;
                pend_ok <= 1'b1;
              end
              3'd2, 3'd3: begin
                state   <= DIV;
                busy    <= 1'b1;
                count   <= 8'(DIV_CYCLES);
                pend_hi <= rem;
                pend_lo <= quot;
                pend_ok <= (b != 32'd0);
              end
              3'd6:    hi <= a;
              3'd7:    lo <= a;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          count <= count - 8'd1;
          if (count == 8'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (pend_ok) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed scenarios pinned with literal values, then a
// randomized run checked every cycle against a timestamp-based reference model.
module tb_mdu_ctrl;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        stall, busy;
  logic [31:0] rdata, hi, lo;

  mdu_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
    .flush(flush), .stall(stall), .busy(busy), .rdata(rdata), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: busy is "current cycle index <= last busy cycle".
  int          cyc = 0;
  int          last_busy = -1;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [31:0] p_hi = 32'd0, p_lo = 32'd0;
  logic        p_ok = 1'b0;
  logic        obs_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_start(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          ps;
    longint unsigned pu;
    int              sx, sy, q, r;
    int unsigned     ux, uy;
    if (o == 3'd0) begin
      ps = longint'($signed(x)) * longint'($signed(y));
      p_hi = ps[63:32]; p_lo = ps[31:0]; p_ok = 1'b1;
      last_busy = cyc + MUL_N;
    end else if (o == 3'd1) begin
      pu = {32'd0, x} * {32'd0, y};
      p_hi = pu[63:32]; p_lo = pu[31:0]; p_ok = 1'b1;
      last_busy = cyc + MUL_N;
    end else if (o == 3'd2) begin
      p_ok = (y != 0);
      if (y != 0) begin
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
          p_lo = 32'h80000000; p_hi = 32'd0;
        end else begin
          sx = int'(x); sy = int'(y);
          q = sx / sy; r = sx % sy;
          p_lo = q; p_hi = r;
        end
      end
      last_busy = cyc + DIV_N;
    end else if (o == 3'd3) begin
      p_ok = (y != 0);
      if (y != 0) begin
        ux = x; uy = y;
        p_lo = ux / uy; p_hi = ux % uy;
      end
      last_busy = cyc + DIV_N;
    end else if (o == 3'd6) m_hi = x;
    else if (o == 3'd7) m_lo = x;
  endtask

  // One clock cycle: drive, check at negedge, advance the model, cross the edge.
  task automatic step(input logic r, input logic [2:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic f);
    logic exp_busy;
    req = r; op = o; a = x; b = y; flush = f;
    @(negedge clk);
    exp_busy = (cyc <= last_busy);
    obs_stall = stall;
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("stall", {31'd0, stall}, {31'd0, r && exp_busy});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    if (r && !exp_busy && (o == 3'd4 || o == 3'd5))
      chk("rdata", rdata, (o == 3'd4) ? m_hi : m_lo);
    if (exp_busy) begin
      if (cyc == last_busy && p_ok) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (r && !f) begin
      model_start(o, x, y);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd4, $urandom, $urandom, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0; last_busy = -1; p_ok = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int stall_cnt;
    logic [31:0] lo_before;
    #2;
    do_reset();

    // MULT -3 * 5
    step(1'b1, 3'd0, 32'hFFFFFFFD, 32'd5, 1'b0);
    idle(MUL_N + 1);
    chk("t1_hi", hi, 32'hFFFFFFFF);
    chk("t1_lo", lo, 32'hFFFFFFF1);

    // MULTU max * max
    step(1'b1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    idle(MUL_N + 1);
    chk("t2_hi", hi, 32'hFFFFFFFE);
    chk("t2_lo", lo, 32'h00000001);

    // DIV -7 / 2, then DIVU by zero leaves HI/LO alone
    step(1'b1, 3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    idle(DIV_N + 1);
    chk("t3_lo", lo, 32'hFFFFFFFD);
    chk("t3_hi", hi, 32'hFFFFFFFF);
    step(1'b1, 3'd3, 32'd7, 32'd0, 1'b0);
    idle(DIV_N + 1);
    chk("t3z_lo", lo, 32'hFFFFFFFD);
    chk("t3z_hi", hi, 32'hFFFFFFFF);

    // Overflow case of signed divide
    step(1'b1, 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    idle(DIV_N + 1);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h00000000);

    // MFHI one cycle after DIV start stalls for the whole window
    step(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
    stall_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 3'd4, $urandom, $urandom, 1'b0);
      if (!obs_stall) break;
      stall_cnt++;
    end
    chk("t4_stall_cycles", stall_cnt, 32'd10);
    chk("t4_hi", hi, 32'd2);
    chk("t4_lo", lo, 32'd14);

    // MTLO with flush is dropped, without flush it lands
    lo_before = m_lo;
    step(1'b1, 3'd7, 32'h12345678, 32'd0, 1'b1);
    idle(1);
    chk("t5_flush_lo", lo, lo_before);
    step(1'b1, 3'd7, 32'h12345678, 32'd0, 1'b0);
    idle(1);
    chk("t5_lo", lo, 32'h12345678);

    // Reset three cycles into a MULT; nothing commits afterwards
    step(1'b1, 3'd0, 32'd1000, 32'd1000, 1'b0);
    idle(2);
    do_reset();
    idle(MUL_N + 2);
    chk("t6_hi", hi, 32'd0);
    chk("t6_lo", lo, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), rand_val(),
                rand_val(), $urandom_range(0, 99) < 15);
    end
    idle(DIV_N + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
